wishbone_arbiter: RTL and testbench
===================================

Name: wishbone_arbiter

Overview:
- Round-robin arbiter that lets NUM_MASTERS classic/burst Wishbone masters share one Wishbone slave port.
- Typical use: packet-interface wishbone_master instances plus a CPU/DMA sharing wishbone_spram at 0x8000.
- Grants the bus per cycle (cyc_i held), muxes the owner's request onto the slave, and routes ack/err back to the owner only.
- A watchdog releases the bus if the slave stalls.

Parameters:
- ADDRESS_WIDTH, 16, Wishbone address width.
- DATA_WIDTH, 8, Wishbone data width.
- DATA_BYTES, 1, number of select lines.
- NUM_MASTERS, 2, number of requesters (2..4).
- TIMEOUT, 16, max cycles with s_stb_o high and no ack before forced release (≥2).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset. Synchronous, active-high.
- m_adr_i  in  NUM_MASTERS*ADDRESS_WIDTH  packed master addresses; master k at slice k.
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  packed master write data.
- m_we_i  in  NUM_MASTERS  write enables.
- m_sel_i  in  NUM_MASTERS*DATA_BYTES  byte selects.
- m_stb_i  in  NUM_MASTERS  strobes.
- m_cyc_i  in  NUM_MASTERS  cycle requests.
- m_cti_i  in  NUM_MASTERS*3  cycle type identifiers.
- m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters.
- m_ack_o  out  NUM_MASTERS  ack, owner bit only.
- m_err_o  out  NUM_MASTERS  watchdog error, owner bit only.
- s_adr_o  out  ADDRESS_WIDTH  slave address.
- s_dat_o  out  DATA_WIDTH  slave write data.
- s_dat_i  in  DATA_WIDTH  slave read data.
- s_we_o  out  1  slave write enable.
- s_sel_o  out  DATA_BYTES  slave byte select.
- s_stb_o  out  1  slave strobe.
- s_cyc_o  out  1  slave cycle.
- s_ack_i  in  1  slave ack.
- s_cti_o  out  3  slave cycle type.
- grant_o  out  NUM_MASTERS  one-hot current owner, 0 when idle.

Behaviour:
- State machine, IDLE → BUSY → IDLE.
- Registers: owner index, last_grant, and a watchdog counter (clog2(TIMEOUT+1) bits).
- Reset (sync, rst_i high at posedge):
  - state=IDLE, last_grant=NUM_MASTERS-1 (master 0 wins first), counter=0.
  - All s_* strobes, m_ack_o, m_err_o and grant_o forced 0 combinationally while rst_i high.
  - A transaction in flight is abandoned; masters must restart.
- IDLE, any m_cyc_i set:
  - Select the first requester searching from last_grant+1 modulo NUM_MASTERS.
  - Next edge: owner=selected, last_grant=selected, state=BUSY.
  - No s_cyc_o in IDLE, so grant latency is 1 cycle from cyc_i.
- BUSY:
  - s_adr_o, s_dat_o, s_we_o, s_sel_o, s_cti_o are combinational muxes of the owner slice.
  - s_cyc_o = m_cyc_i[owner]; s_stb_o = m_stb_i[owner].
  - m_ack_o = s_ack_i one-hot at owner; m_dat_o = s_dat_i always.
  - grant_o = one-hot(owner).
- Owner drops m_cyc_i:
  - s_cyc_o/s_stb_o fall the same cycle; state returns to IDLE at the next edge.
  - This forces exactly one idle turnaround cycle between grants, even if other masters are waiting.
- Bursts (cti 3'b010) need no special handling. The owner keeps the bus until cyc falls, regardless of cti 3'b111.
- Non-owner requests are held off (no ack). The arbiter never preempts except via the watchdog.
- Watchdog:
  - Counter clears on s_ack_i or when s_stb_o is low; it increments while s_stb_o is high and s_ack_i is low.
  - When the counter reaches TIMEOUT: m_err_o[owner] pulses for 1 cycle, s_cyc_o/s_stb_o are masked that cycle, and state goes to IDLE at the next edge.
  - The same master is not re-granted until the arbiter has passed through IDLE; round-robin then proceeds normally.
- Simultaneous events:
  - Ack arriving in the TIMEOUT cycle takes priority: ack delivered, no err, counter clears.
  - Owner drops cyc in the TIMEOUT cycle: normal release, no err.
- Single-requester case: that master is re-granted after the one turnaround cycle.

Decomposition:
- Shared package wb_pkg holds:
  - CTI constants CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111.
  - State encoding IDLE/BUSY.
  - clog2 helper.
- One sub-module, rr_select: combinational round-robin priority picker (requests, last_grant → index, valid). It is reusable for other shared resources.

Test Plan:
1. Reset, then m_cyc_i=2'b01, single write 0x8000←0x5A. Expect s_cyc_o high 1 cycle after cyc_i, only m_ack_o[0] pulses, and readback of 0x8000 via master 1 returns 0x5A.
2. Both masters raise cyc in the same cycle after reset. Expect master 0 granted first (grant_o=01), then 1 turnaround cycle, then grant_o=10.
3. Master 0 does an 8-beat burst write 0x8000..0x8007 = 0x00..0x77 (cti 010, last 111) while master 1 requests mid-burst. Expect no interleave: grant_o stays 01 for all 8 acks, master 1 served after.
4. Slave ack tied low, TIMEOUT=16. Expect m_err_o[owner] one pulse on the 16th stb-without-ack cycle and grant_o=0 the next cycle.
5. Assert rst_i mid-burst after 3 acks. Expect s_cyc_o=0 and grant_o=0 in the reset cycle; after reset, master 0 wins the first arbitration.
6. Master 0 re-requests continuously with master 1 also requesting. Expect strict alternation 0,1,0,1 over 4 grants.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: cycle type identifiers, arbiter
// state encoding and a constant-safe clog2 helper.
package wb_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: returns the first set request
// searching upward from last+1 (mod N). Ports: req, last -> idx, valid.
module rr_select
   import wb_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [IW-1:0] idx,
   output logic          valid
);

   logic [IW-1:0] cand;

   // Scan from the farthest candidate to the nearest so that the
   // nearest requester after 'last' is the final assignment.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      for (int i = N; i >= 1; i--) begin
         cand = IW'((int'(last) + i) % N);
         if (req[cand]) begin
            idx   = cand;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave among NUM_MASTERS
// masters, with a stall watchdog.
// Ports: clk_i/rst_i; packed m_* master requests in, m_dat_o/m_ack_o/
// m_err_o back; s_* slave port; grant_o one-hot current owner.
module wishbone_arbiter
   import wb_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 16,
   parameter int DATA_WIDTH    = 8,
   parameter int DATA_BYTES    = 1,
   parameter int NUM_MASTERS   = 2,
   parameter int TIMEOUT       = 16
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0]  m_adr_i,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_dat_i,
   input  logic [NUM_MASTERS-1:0]                m_we_i,
   input  logic [NUM_MASTERS*DATA_BYTES-1:0]     m_sel_i,
   input  logic [NUM_MASTERS-1:0]                m_stb_i,
   input  logic [NUM_MASTERS-1:0]                m_cyc_i,
   input  logic [NUM_MASTERS*3-1:0]              m_cti_i,
   output logic [DATA_WIDTH-1:0]                 m_dat_o,
   output logic [NUM_MASTERS-1:0]                m_ack_o,
   output logic [NUM_MASTERS-1:0]                m_err_o,
   output logic [ADDRESS_WIDTH-1:0]              s_adr_o,
   output logic [DATA_WIDTH-1:0]                 s_dat_o,
   input  logic [DATA_WIDTH-1:0]                 s_dat_i,
   output logic                                  s_we_o,
   output logic [DATA_BYTES-1:0]                 s_sel_o,
   output logic                                  s_stb_o,
   output logic                                  s_cyc_o,
   input  logic                                  s_ack_i,
   output logic [2:0]                            s_cti_o,
   output logic [NUM_MASTERS-1:0]                grant_o
);

   localparam int IW = clog2(NUM_MASTERS);
   localparam int CW = clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] WD_LAST   = CW'(TIMEOUT - 1);
   localparam logic [IW-1:0] LAST_INIT = IW'(NUM_MASTERS - 1);

   state_t                 state;
   logic [IW-1:0]          owner;
   logic [IW-1:0]          last_grant;
   logic [IW-1:0]          sel_idx;
   logic                   sel_valid;
   logic [CW-1:0]          wd_cnt;
   logic [NUM_MASTERS-1:0] owner_oh;
   logic                   busy;
   logic                   own_cyc;
   logic                   own_stb;
   logic                   stall;
   logic                   expire;

   rr_select #(
      .N  (NUM_MASTERS),
      .IW (IW)
   ) u_rr (
      .req   (m_cyc_i),
      .last  (last_grant),
      .idx   (sel_idx),
      .valid (sel_valid)
   );

   assign owner_oh = NUM_MASTERS'(1) << owner;
   assign busy     = (state == BUSY) && !rst_i;
   assign own_cyc  = m_cyc_i[owner];
   assign own_stb  = m_stb_i[owner];
   assign stall    = busy && own_cyc && own_stb && !s_ack_i;

   // wd_cnt holds the stalled cycles already seen, so the TIMEOUT-th
   // consecutive stalled cycle is the one where it equals TIMEOUT-1.
   assign expire   = stall && (wd_cnt == WD_LAST);

   assign s_adr_o = m_adr_i[int'(owner)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
   assign s_dat_o = m_dat_i[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
   assign s_sel_o = m_sel_i[int'(owner)*DATA_BYTES +: DATA_BYTES];
   assign s_cti_o = m_cti_i[int'(owner)*3 +: 3];
   assign s_we_o  = m_we_i[owner];

   assign s_cyc_o = busy && own_cyc && !expire;
   assign s_stb_o = busy && own_cyc && own_stb && !expire;

   assign m_dat_o = s_dat_i;
   assign m_ack_o = (busy && own_cyc && s_ack_i) ? owner_oh : '0;
   assign m_err_o = expire ? owner_oh : '0;
   assign grant_o = busy ? owner_oh : '0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         owner      <= '0;
         last_grant <= LAST_INIT;
         wd_cnt     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               wd_cnt <= '0;
               if (sel_valid) begin
                  owner      <= sel_idx;
                  last_grant <= sel_idx;
                  state      <= BUSY;
               end
            end
            BUSY: begin
               // Any release passes through IDLE, which gives the
               // mandatory turnaround cycle between owners.
               if (!own_cyc || expire) begin
                  state  <= IDLE;
                  wd_cnt <= '0;
               end else if (stall) begin
                  wd_cnt <= wd_cnt + CW'(1);
               end else begin
                  wd_cnt <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Self-checking bench for wishbone_arbiter: bus-functional masters,
// a registered-ack slave memory and a transaction-level reference.
`timescale 1ns/1ps
module tb_wishbone_arbiter;

   localparam int N  = 2;
   localparam int AW = 16;
   localparam int DW = 8;
   localparam int TO = 16;

   typedef struct {
      logic [15:0] adr;
      logic [7:0]  dat;
      bit          we;
      logic [2:0]  cti;
      bit          last;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [AW-1:0] adr [N];
   logic [DW-1:0] wdat [N];
   logic [2:0]    cti [N];
   logic [N-1:0]  cyc = '0;
   logic [N-1:0]  stb = '0;
   logic [N-1:0]  we = '0;
   logic [N-1:0]  sel = '1;

   logic [DW-1:0] m_dat;
   logic [N-1:0]  m_ack, m_err, grant;
   logic [AW-1:0] s_adr;
   logic [DW-1:0] s_wdat;
   logic [DW-1:0] s_rdat;
   logic          s_we, s_stb, s_cyc, s_ack;
   logic [0:0]    s_sel;
   logic [2:0]    s_cti;

   wishbone_arbiter #(
      .ADDRESS_WIDTH (AW),
      .DATA_WIDTH    (DW),
      .DATA_BYTES    (1),
      .NUM_MASTERS   (N),
      .TIMEOUT       (TO)
   ) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .m_adr_i ({adr[1], adr[0]}),
      .m_dat_i ({wdat[1], wdat[0]}),
      .m_we_i  (we),
      .m_sel_i (sel),
      .m_stb_i (stb),
      .m_cyc_i (cyc),
      .m_cti_i ({cti[1], cti[0]}),
      .m_dat_o (m_dat),
      .m_ack_o (m_ack),
      .m_err_o (m_err),
      .s_adr_o (s_adr),
      .s_dat_o (s_wdat),
      .s_dat_i (s_rdat),
      .s_we_o  (s_we),
      .s_sel_o (s_sel),
      .s_stb_o (s_stb),
      .s_cyc_o (s_cyc),
      .s_ack_i (s_ack),
      .s_cti_o (s_cti),
      .grant_o (grant)
   );

   // Slave: accepts a strobe, acks one cycle later; stall holds off.
   bit         stall_slave;
   logic [7:0] slave_mem [256];
   always @(posedge clk) begin
      if (rst) begin
         s_ack <= 1'b0;
         for (int i = 0; i < 256; i++) slave_mem[i] <= 8'h00;
      end else if (s_cyc && s_stb && !s_ack && !stall_slave) begin
         s_ack  <= 1'b1;
         s_rdat <= slave_mem[s_adr[7:0]];
         if (s_we) slave_mem[s_adr[7:0]] <= s_wdat;
      end else begin
         s_ack <= 1'b0;
      end
   end

   int n_assert = 0;
   int n_fail   = 0;

   beat_t      q [N][$];
   int         hold [N];
   int         ack_cnt [N];
   int         err_cnt [N];
   logic [7:0] mdl_mem [256];

   // Reference: owner (-1 = bus free), last winner, stalled-cycle run.
   int mo = -1;
   int ml = N - 1;
   int mwd = 0;

   logic [23:0] exp_vec, smp_vec;
   logic [N-1:0] smp_grant, smp_ack, smp_err;
   logic         smp_scyc;
   bit           rd_valid;
   logic [7:0]   rd_got, rd_exp;

   function automatic bit pending();
      return q[0].size() != 0 || q[1].size() != 0 ||
             hold[0] != 0 || hold[1] != 0;
   endfunction

   task automatic push_job(input int k, input logic [15:0] base,
                           input int len, input bit w,
                           input logic [7:0] d0, input logic [7:0] step);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.adr  = base + 16'(i);
         b.dat  = d0 + 8'(i) * step;
         b.we   = w;
         b.last = (i == len - 1);
         if (len == 1) b.cti = 3'b000;
         else b.cti = b.last ? 3'b111 : 3'b010;
         q[k].push_back(b);
      end
   endtask

   task automatic cycle();
      logic [N-1:0] eg, ea, ee;
      logic         ec, es;
      logic [15:0]  ead;
      bit           stalled;
      beat_t        b;
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
         if (hold[k] > 0 || q[k].size() == 0) begin
            if (hold[k] > 0) hold[k]--;
            cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
            adr[k] = '0; wdat[k] = '0; cti[k] = '0;
         end else begin
            cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = q[k][0].we;
            adr[k] = q[k][0].adr; wdat[k] = q[k][0].dat;
            cti[k] = q[k][0].cti;
         end
      end
      #2;
      eg = '0; ea = '0; ee = '0; ec = 1'b0; es = 1'b0; ead = '0;
      stalled = 1'b0;
      if (!rst && mo >= 0) begin
         eg[mo] = 1'b1;
         if (cyc[mo]) begin
            stalled = stb[mo] && !s_ack;
            if (stalled && mwd == TO - 1) begin
               ee[mo] = 1'b1;
            end else begin
               ec = 1'b1; es = stb[mo]; ea[mo] = s_ack; ead = adr[mo];
            end
         end
      end
      exp_vec   = {eg, ea, ee, ec, es, ead};
      smp_grant = grant; smp_ack = m_ack; smp_err = m_err;
      smp_scyc  = s_cyc;
      smp_vec   = {grant, m_ack, m_err, s_cyc, s_stb,
                   s_cyc ? s_adr : 16'h0000};
      rd_valid = 1'b0;
      @(posedge clk);
      #1;
      if (rst) begin
         mo = -1; ml = N - 1; mwd = 0;
         for (int i = 0; i < 256; i++) mdl_mem[i] = 8'h00;
      end else if (mo < 0) begin
         for (int i = 1; i <= N && mo < 0; i++)
            if (cyc[(ml + i) % N]) begin
               mo = (ml + i) % N;
               ml = mo;
            end
      end else if (!cyc[mo] || ee != 0) begin
         mo = -1; mwd = 0;
      end else begin
         mwd = stalled ? mwd + 1 : 0;
      end
      for (int k = 0; k < N; k++) begin
         if (smp_err[k]) begin
            err_cnt[k]++;
            while (q[k].size() != 0) begin
               b = q[k].pop_front();
               if (b.last) break;
            end
            hold[k] = 1;
         end else if (smp_ack[k] && q[k].size() != 0) begin
            b = q[k].pop_front();
            ack_cnt[k]++;
            if (b.we) begin
               mdl_mem[b.adr[7:0]] = b.dat;
            end else begin
               rd_valid = 1'b1;
               rd_got   = m_dat;
               rd_exp   = mdl_mem[b.adr[7:0]];
            end
            if (b.last) hold[k] = 1;
         end
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      int first;
      first = -1;
      push_job(1, 16'h8020, 1, 1'b1, 8'hC3, 8'h00);
      repeat (3) begin
         cycle();
         n_assert++;
         if (smp_vec !== exp_vec || smp_grant !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required %h", smp_vec, exp_vec);
         end
      end
      rst = 1'b0;
      for (int n = 0; n < 40 && pending(); n++) begin
         cycle();
         n_assert++;
         if (smp_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL reset_release: got %h required %h", smp_vec, exp_vec);
         end
         if (first < 0 && smp_grant != 0) first = int'(smp_grant);
      end
      n_assert++;
      if (first != 2 || pending()) begin
         n_fail++;
         $display("FAIL reset_first_grant: got %0d required 2", first);
      end
   endtask

   task automatic test_single_write();
      int n_cyc, n_scyc, a1;
      n_cyc = -1; n_scyc = -1;
      apply_reset();
      a1 = ack_cnt[1];
      push_job(0, 16'h8000, 1, 1'b1, 8'h5A, 8'h00);
      for (int n = 0; n < 40 && pending(); n++) begin
         cycle();
         n_assert++;
         if (smp_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL single_write: got %h required %h", smp_vec, exp_vec);
         end
         if (n_cyc < 0 && cyc[0]) n_cyc = n;
         if (n_scyc < 0 && smp_scyc) n_scyc = n;
      end
      n_assert++;
      if (n_scyc - n_cyc != 1 || ack_cnt[1] != a1) begin
         n_fail++;
         $display("FAIL grant_latency: got %0d required 1", n_scyc - n_cyc);
      end
      push_job(1, 16'h8000, 1, 1'b0, 8'h00, 8'h00);
      for (int n = 0; n < 40 && pending(); n++) begin
         cycle();
         if (rd_valid) begin
            n_assert++;
            if (rd_got !== 8'h5A) begin
               n_fail++;
               $display("FAIL readback: got %h required 5a", rd_got);
            end
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [1:0] tr[$];
      int last01, first10;
      last01 = -1; first10 = -1;
      apply_reset();
      push_job(0, 16'h8030, 1, 1'b1, 8'h11, 8'h00);
      push_job(1, 16'h8031, 1, 1'b1, 8'h22, 8'h00);
      for (int n = 0; n < 60 && pending(); n++) begin
         cycle();
         tr.push_back(smp_grant);
         n_assert++;
         if (smp_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL simultaneous: got %h required %h", smp_vec, exp_vec);
         end
      end
      for (int i = 0; i < tr.size(); i++) begin
         if (tr[i] == 2'b10 && first10 < 0) first10 = i;
         if (tr[i] == 2'b01 && first10 < 0) last01 = i;
      end
      n_assert++;
      if (last01 < 0 || first10 - last01 != 2) begin
         n_fail++;
         $display("FAIL turnaround: got gap %0d required 2", first10 - last01);
      end
   endtask

   task automatic test_burst();
      bit pushed, m0_done;
      int a0, acks_under_grant;
      pushed = 0; m0_done = 0; acks_under_grant = 0;
      a0 = ack_cnt[0];
      push_job(0, 16'h8000, 8, 1'b1, 8'h00, 8'h11);
      for (int n = 0; n < 120 && pending(); n++) begin
         cycle();
         n_assert++;
         if (smp_vec !== exp_vec || (!m0_done && smp_grant[1])) begin
            n_fail++;
            $display("FAIL burst: got %h required %h", smp_vec, exp_vec);
         end
         if (smp_ack[0] && smp_grant == 2'b01) acks_under_grant++;
         if (ack_cnt[0] - a0 == 8) m0_done = 1;
         if (!pushed && ack_cnt[0] - a0 == 3) begin
            push_job(1, 16'h8003, 1, 1'b0, 8'h00, 8'h00);
            pushed = 1;
         end
         if (rd_valid) begin
            n_assert++;
            if (rd_got !== 8'h33) begin
               n_fail++;
               $display("FAIL burst_read: got %h required 33", rd_got);
            end
         end
      end
      n_assert++;
      if (acks_under_grant != 8 || pending()) begin
         n_fail++;
         $display("FAIL burst_acks: got %0d required 8", acks_under_grant);
      end
   endtask

   task automatic test_timeout();
      int stall_n, err_at, err_n, err_cyc;
      logic [1:0] after;
      stall_n = 0; err_at = -1; err_n = 0; err_cyc = -1; after = 2'b11;
      stall_slave = 1'b1;
      push_job(0, 16'h80F0, 1, 1'b1, 8'hEE, 8'h00);
      for (int n = 0; n < 40; n++) begin
         cycle();
         n_assert++;
         if (smp_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL timeout_cycle: got %h required %h", smp_vec, exp_vec);
         end
         if (smp_grant[0] && cyc[0] && stb[0] && !s_ack) stall_n++;
         if (n == err_cyc + 1 && err_cyc >= 0) after = smp_grant;
         if (smp_err != 0) begin
            err_n++;
            if (err_at < 0) begin
               err_at = stall_n; err_cyc = n;
               n_assert++;
               if (smp_err !== 2'b01) begin
                  n_fail++;
                  $display("FAIL err_owner: got %b required 01", smp_err);
               end
            end
         end
      end
      n_assert++;
      if (err_at != TO || err_n != 1) begin
         n_fail++;
         $display("FAIL watchdog: got err at %0d (%0d pulses) required %0d (1)",
                  err_at, err_n, TO);
      end
      n_assert++;
      if (after !== 2'b00) begin
         n_fail++;
         $display("FAIL watchdog_release: got %b required 00", after);
      end
      stall_slave = 1'b0;
   endtask

   task automatic test_reset_midburst();
      int a0, first;
      first = -1;
      a0 = ack_cnt[0];
      push_job(0, 16'h8010, 8, 1'b1, 8'h40, 8'h01);
      for (int n = 0; n < 80 && ack_cnt[0] - a0 < 3; n++) cycle();
      rst = 1'b1;
      cycle();
      n_assert++;
      if (smp_scyc !== 1'b0 || smp_grant !== 2'b00 || !cyc[0]) begin
         n_fail++;
         $display("FAIL reset_midburst: got cyc=%b grant=%b required 0 00",
                  smp_scyc, smp_grant);
      end
      rst = 1'b0;
      for (int k = 0; k < N; k++) begin
         q[k].delete();
         hold[k] = 0;
      end
      push_job(0, 16'h8040, 1, 1'b1, 8'h01, 8'h00);
      push_job(1, 16'h8041, 1, 1'b1, 8'h02, 8'h00);
      for (int n = 0; n < 60 && pending(); n++) begin
         cycle();
         n_assert++;
         if (smp_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL post_reset: got %h required %h", smp_vec, exp_vec);
         end
         if (first < 0 && smp_grant != 0) first = int'(smp_grant);
      end
      n_assert++;
      if (first != 1) begin
         n_fail++;
         $display("FAIL post_reset_winner: got %0d required 1", first);
      end
   endtask

   task automatic test_alternation();
      int seq[$];
      int want[4];
      logic [1:0] prev;
      want = '{0, 1, 0, 1};
      prev = 2'b00;
      apply_reset();
      for (int j = 0; j < 2; j++) begin
         push_job(0, 16'h8050 + 16'(j), 1, 1'b1, 8'h70, 8'h00);
         push_job(1, 16'h8060 + 16'(j), 1, 1'b1, 8'h80, 8'h00);
      end
      for (int n = 0; n < 80 && pending(); n++) begin
         cycle();
         n_assert++;
         if (smp_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL alternation_cycle: got %h required %h", smp_vec, exp_vec);
         end
         if (prev == 2'b00 && smp_grant != 2'b00)
            seq.push_back(smp_grant[1] ? 1 : 0);
         prev = smp_grant;
      end
      for (int i = 0; i < 4; i++) begin
         n_assert++;
         if (i >= seq.size() || seq[i] != want[i]) begin
            n_fail++;
            $display("FAIL alternation_%0d: got %0d required %0d", i,
                     i < seq.size() ? seq[i] : -1, want[i]);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         for (int k = 0; k < N; k++)
            if (n < 500 && q[k].size() == 0 && $urandom_range(3) == 0)
               push_job(k, 16'h8000 | 16'($urandom_range(255)),
                        $urandom_range(4, 1), 1'($urandom_range(1)),
                        8'($urandom), 8'($urandom));
         stall_slave = (n < 500) && ($urandom_range(3) == 0);
         cycle();
         n_assert++;
         if (smp_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL random_cycle %0d: got %h required %h", n,
                     smp_vec, exp_vec);
         end
         if (rd_valid) begin
            n_assert++;
            if (rd_got !== rd_exp) begin
               n_fail++;
               $display("FAIL random_read %0d: got %h required %h", n,
                        rd_got, rd_exp);
            end
         end
      end
      n_assert++;
      if (pending()) begin
         n_fail++;
         $display("FAIL random_drain: got pending jobs required none");
      end
   endtask

   initial begin
      for (int k = 0; k < N; k++) begin
         adr[k] = '0; wdat[k] = '0; cti[k] = '0;
         hold[k] = 0; ack_cnt[k] = 0; err_cnt[k] = 0;
      end
      for (int i = 0; i < 256; i++) mdl_mem[i] = 8'h00;
      stall_slave = 1'b0;
      test_reset();
      test_single_write();
      test_simultaneous();
      test_burst();
      test_timeout();
      test_reset_midburst();
      test_alternation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
